// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: opcodes, states,
// datapath select encodings and opcode classes.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_IMM    = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_MEM    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_SYS,
        CLS_ILLEGAL
    } opclass_e;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode-to-class decode, shared by the DECODE and EXEC steps.
module opcode_class
    import cpu_pkg::*;
(
    input  logic [6:0] opcode_i,
    output opclass_e   cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_R:      cls_o = CLS_R;
            OP_I:      cls_o = CLS_I;
            OP_LOAD:   cls_o = CLS_LOAD;
            OP_STORE:  cls_o = CLS_STORE;
            OP_BRANCH: cls_o = CLS_BRANCH;
            OP_JAL:    cls_o = CLS_JAL;
            OP_JALR:   cls_o = CLS_JALR;
            OP_LUI:    cls_o = CLS_LUI;
            OP_AUIPC:  cls_o = CLS_AUIPC;
            OP_SYSTEM: cls_o = CLS_SYS;
            default:   cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing controller: FETCH/DECODE/EXEC/MEM/WB with bounded
// memory waits, retired-instruction counter and terminal HALT/FAULT states.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             alu_a_pc,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             halt,
    output logic             fault,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_dbg
);

    localparam int unsigned      WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit               TMO_EN    = (TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    opclass_e          cls;
    logic              retire;

    logic       imem_req_c, dmem_req_c, dmem_we_c, ir_we_c, pc_we_c;
    logic       alu_src_c, alu_a_pc_c, reg_we_c, halt_c, fault_c;
    logic [1:0] pc_src_c, alu_op_c, wb_sel_c;

    opcode_class u_opcode_class (
        .opcode_i (opcode),
        .cls_o    (cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and per-cycle datapath controls.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_src_c   = PC_PLUS4;
        alu_op_c   = ALU_ADD;
        alu_src_c  = 1'b0;
        alu_a_pc_c = 1'b0;
        reg_we_c   = 1'b0;
        wb_sel_c   = WB_ALU;
        halt_c     = 1'b0;
        fault_c    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = ST_DECODE;
                end else if (TMO_EN && wait_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                case (cls)
                    CLS_SYS:     state_d = ST_HALT;
                    CLS_ILLEGAL: state_d = ST_FAULT;
                    default:     state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                state_d = ST_WB;
                case (cls)
                    CLS_R: alu_op_c = ALU_FUNCT;
                    CLS_I: begin
                        alu_op_c  = ALU_FUNCT;
                        alu_src_c = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_c = 1'b1;
                        state_d   = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op_c = ALU_CMP;
                        pc_we_c  = branch_taken;
                        pc_src_c = PC_IMM;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_LUI: begin
                        alu_op_c  = ALU_PASSB;
                        alu_src_c = 1'b1;
                    end
                    CLS_AUIPC: begin
                        alu_src_c  = 1'b1;
                        alu_a_pc_c = 1'b1;
                    end
                    CLS_JAL, CLS_JALR: alu_src_c = 1'b1;
                    default: state_d = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (cls == CLS_STORE);
                if (dmem_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_we_c  = 1'b1;
                        pc_src_c = PC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (TMO_EN && wait_q == WAIT_LAST) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                retire   = 1'b1;
                state_d  = ST_FETCH;
                case (cls)
                    CLS_LOAD: wb_sel_c = WB_MEM;
                    CLS_JAL: begin
                        wb_sel_c = WB_PC4;
                        pc_src_c = PC_IMM;
                    end
                    CLS_JALR: begin
                        wb_sel_c = WB_PC4;
                        pc_src_c = PC_JALR;
                    end
                    default: wb_sel_c = WB_ALU;
                endcase
            end
            ST_HALT:  halt_c  = 1'b1;
            ST_FAULT: fault_c = 1'b1;
            default:  state_d = ST_FAULT;
        endcase
    end

    // Wait counter restarts whenever the state changes, so entry to FETCH/MEM sees zero.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((state_q == ST_FETCH && !imem_ready) ||
                     (state_q == ST_MEM && !dmem_ready)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // Controls are forced low while reset is held, without waiting for a clock edge.
    assign imem_req  = rst_n & imem_req_c;
    assign dmem_req  = rst_n & dmem_req_c;
    assign dmem_we   = rst_n & dmem_we_c;
    assign ir_we     = rst_n & ir_we_c;
    assign pc_we     = rst_n & pc_we_c;
    assign pc_src    = rst_n ? pc_src_c : 2'b00;
    assign alu_op    = rst_n ? alu_op_c : 2'b00;
    assign alu_src   = rst_n & alu_src_c;
    assign alu_a_pc  = rst_n & alu_a_pc_c;
    assign reg_we    = rst_n & reg_we_c;
    assign wb_sel    = rst_n ? wb_sel_c : 2'b00;
    assign halt      = rst_n & halt_c;
    assign fault     = rst_n & fault_c;
    assign instret   = instret_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction cycle traces built from
// the instruction-class rules, compared against the DUT every cycle.
module tb_multicycle_ctrl;

    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        branch_taken, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0]  pc_src, alu_op, wb_sel;
    logic        alu_src, alu_a_pc, reg_we, halt, fault;
    logic [31:0] instret;
    logic [2:0]  state_dbg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int base;

    typedef struct {
        logic [6:0]  op;
        logic        tk;
        logic        ir;
        logic        dr;
        logic [18:0] exp;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t        trace[$];
    logic [31:0] m_instret;

    multicycle_ctrl #(.TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .alu_a_pc     (alu_a_pc),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .halt         (halt),
        .fault        (fault),
        .instret      (instret),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    // {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op,
    //  alu_src, alu_a_pc, reg_we, wb_sel, halt, fault}
    function automatic logic [18:0] ov(input logic [2:0] st, input logic [4:0] rq,
                                       input logic [1:0] pcs, input logic [1:0] aop,
                                       input logic [2:0] ab, input logic [1:0] wbs,
                                       input logic [1:0] hf);
        return {st, rq, pcs, aop, ab, wbs, hf};
    endfunction

    function automatic logic [18:0] act_vec();
        return {state_dbg, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op,
                alu_src, alu_a_pc, reg_we, wb_sel, halt, fault};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic tk, input logic ir,
                        input logic dr, input logic [18:0] e);
        cyc_t c;
        c.op = op; c.tk = tk; c.ir = ir; c.dr = dr; c.exp = e; c.cnt = m_instret;
        trace.push_back(c);
    endtask

    task automatic gen_fetch(input logic [6:0] op, input logic tk, input int idly);
        for (int i = 0; i < idly; i++) push(op, tk, 1'b0, 1'b0, ov(3'd0, 5'b10000, 2'd0, 2'd0, 3'b000, 2'd0, 2'b00));
        push(op, tk, 1'b1, 1'b0, ov(3'd0, 5'b10010, 2'd0, 2'd0, 3'b000, 2'd0, 2'b00));
        push(op, tk, 1'b1, 1'b1, ov(3'd1, 5'b00000, 2'd0, 2'd0, 3'b000, 2'd0, 2'b00));
    endtask

    // One complete legal instruction, shaped by the class rules.
    task automatic gen_instr(input logic [6:0] op, input logic tk, input int idly, input int ddly);
        logic [1:0] aop, pcs, wbs;
        logic       asrc, apc, is_br, is_mem, is_st;
        gen_fetch(op, tk, idly);
        asrc = 1'b1; apc = 1'b0; aop = 2'b00;
        is_br = (op == 7'b1100011);
        is_st = (op == 7'b0100011);
        is_mem = is_st || (op == 7'b0000011);
        case (op)
            7'b0110011: begin aop = 2'b10; asrc = 1'b0; end
            7'b0010011: aop = 2'b10;
            7'b1100011: begin aop = 2'b01; asrc = 1'b0; end
            7'b0110111: aop = 2'b11;
            7'b0010111: apc = 1'b1;
            default: aop = 2'b00;
        endcase
        push(op, tk, 1'b1, 1'b1, ov(3'd2, {4'b0000, is_br & tk}, is_br ? 2'd1 : 2'd0, aop,
                                     {asrc, apc, 1'b0}, 2'd0, 2'b00));
        if (is_br) begin
            m_instret++;
            return;
        end
        if (is_mem) begin
            for (int i = 0; i < ddly; i++)
                push(op, tk, 1'b0, 1'b0, ov(3'd3, {2'b01, is_st, 2'b00}, 2'd0, 2'd0, 3'b000, 2'd0, 2'b00));
            push(op, tk, 1'b0, 1'b1, ov(3'd3, {2'b01, is_st, 1'b0, is_st}, 2'd0, 2'd0, 3'b000, 2'd0, 2'b00));
            if (is_st) begin
                m_instret++;
                return;
            end
        end
        wbs = (op == 7'b0000011) ? 2'd1 : (op == 7'b1101111 || op == 7'b1100111) ? 2'd2 : 2'd0;
        pcs = (op == 7'b1101111) ? 2'd1 : (op == 7'b1100111) ? 2'd2 : 2'd0;
        push(op, tk, 1'b0, 1'b0, ov(3'd4, 5'b00001, pcs, 2'd0, 3'b001, wbs, 2'b00));
        m_instret++;
    endtask

    task automatic gen_term(input logic [6:0] op, input logic is_halt, input int n);
        gen_fetch(op, 1'b0, 0);
        for (int i = 0; i < n; i++)
            push(op, 1'b0, 1'b1, 1'b1, ov(is_halt ? 3'd5 : 3'd6, 5'b00000, 2'd0, 2'd0, 3'b000, 2'd0,
                                          is_halt ? 2'b10 : 2'b01));
    endtask

    task automatic gen_timeout(input int n);
        for (int i = 0; i < int'(TMO); i++)
            push(7'b0110011, 1'b0, 1'b0, 1'b0, ov(3'd0, 5'b10000, 2'd0, 2'd0, 3'b000, 2'd0, 2'b00));
        for (int i = 0; i < n; i++)
            push(7'b0110011, 1'b0, 1'b1, 1'b1, ov(3'd6, 5'b00000, 2'd0, 2'd0, 3'b000, 2'd0, 2'b01));
    endtask

    // Drives each recorded cycle on the falling edge and compares the outputs shortly after.
    task automatic run_trace(input int n);
        cyc_t c;
        for (int k = 0; k < n && trace.size() > 0; k++) begin
            c = trace.pop_front();
            @(negedge clk);
            opcode = c.op; branch_taken = c.tk; imem_ready = c.ir; dmem_ready = c.dr;
            #1;
            cyc++;
            check("outputs", 32'(act_vec()), 32'(c.exp));
            check("instret", instret, c.cnt);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        check("rst_outputs", 32'(act_vec()), 32'd0);
        check("rst_instret", instret, 32'd0);
        @(posedge clk);
        #2;
        check("rst_hold_outputs", 32'(act_vec()), 32'd0);
        rst_n = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        m_instret = 32'd0;
    endtask

    task automatic check_count_after_edge(input string nm, input logic [31:0] exp);
        @(posedge clk);
        #1;
        check(nm, instret, exp);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; m_instret = 32'd0;
        do_reset();

        base = trace.size(); gen_instr(7'b0110011, 1'b0, 0, 0);
        check("len_rtype", 32'(trace.size() - base), 32'd4);
        run_trace(100);
        check_count_after_edge("instret_after_rtype", 32'd1);

        base = trace.size(); gen_instr(7'b0000011, 1'b0, 0, 3);
        check("len_load_d3", 32'(trace.size() - base), 32'd8);
        base = trace.size(); gen_instr(7'b1100011, 1'b1, 0, 0);
        check("len_branch", 32'(trace.size() - base), 32'd3);
        gen_instr(7'b1100011, 1'b0, 0, 0);
        base = trace.size(); gen_instr(7'b0100011, 1'b0, 0, 0);
        check("len_store", 32'(trace.size() - base), 32'd4);
        gen_instr(7'b0110111, 1'b0, 0, 0);
        gen_instr(7'b0010111, 1'b0, 0, 0);
        gen_instr(7'b1101111, 1'b0, 0, 0);
        gen_instr(7'b1100111, 1'b0, 0, 0);
        gen_instr(7'b0010011, 1'b0, 2, 0);
        gen_instr(7'b0110011, 1'b0, int'(TMO) - 1, 0);
        gen_instr(7'b0000011, 1'b0, 0, int'(TMO) - 1);
        run_trace(1000);
        check_count_after_edge("instret_after_program", 32'd12);

        // Reset while a load is waiting in MEM.
        gen_instr(7'b0000011, 1'b0, 0, 6);
        run_trace(4);
        check("mem_req_before_rst", 32'(dmem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'd0);
        check("mid_rst_instret", instret, 32'd0);
        trace.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
        m_instret = 32'd0;

        gen_term(7'b1110011, 1'b1, 5);
        run_trace(100);
        check("halt_sticky", 32'(halt), 32'd1);
        do_reset();
        gen_term(7'b0000000, 1'b0, 5);
        run_trace(100);
        check("fault_sticky", 32'(fault), 32'd1);
        do_reset();

        gen_instr(7'b0110011, 1'b0, 0, 0);
        gen_timeout(4);
        run_trace(100);
        check("timeout_instret_frozen", instret, 32'd1);
        do_reset();
        gen_instr(7'b0010011, 1'b0, 0, 0);
        run_trace(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
